// File: rtl/bg_remove_if.sv
// Pixel stream bundle for the background-removal engine: one valid/ready
// input stream and one valid/ready output stream carrying RGB pixels.
interface bg_remove_if #(
   parameter int PIX_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] in_red;
   logic [PIX_W-1:0] in_green;
   logic [PIX_W-1:0] in_blue;

   logic             out_valid;
   logic             out_ready;
   logic [PIX_W-1:0] out_red;
   logic [PIX_W-1:0] out_green;
   logic [PIX_W-1:0] out_blue;
   logic             out_is_bg;

   // Pixel producer / result consumer side
   modport master (
      output in_valid, in_red, in_green, in_blue, out_ready,
      input  in_ready, out_valid, out_red, out_green, out_blue, out_is_bg
   );

   // Engine side
   modport slave (
      input  in_valid, in_red, in_green, in_blue, out_ready,
      output in_ready, out_valid, out_red, out_green, out_blue, out_is_bg
   );
endinterface

// File: rtl/bg_remove_engine.sv
// Per-segment RGB engine: either accumulates channel sums over NUM_PIXELS pixels,
// or replaces pixels close to an expected background colour with a fill colour.
module bg_remove_engine #(
   parameter  int PIX_W      = 8,
   parameter  int NUM_PIXELS = 16,
   parameter  int CNT_W      = 5,
   parameter  int SUM_W      = 12,
   localparam int DIST_W     = 2*PIX_W+2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start_Sum,
   input  logic              Start_BgRemoval,
   input  logic              Ack,
   input  logic [PIX_W-1:0]  red_exp,
   input  logic [PIX_W-1:0]  green_exp,
   input  logic [PIX_W-1:0]  blue_exp,
   input  logic [DIST_W-1:0] threshold,
   input  logic [PIX_W-1:0]  bg_red,
   input  logic [PIX_W-1:0]  bg_green,
   input  logic [PIX_W-1:0]  bg_blue,
   bg_remove_if.slave        pix,
   output logic [SUM_W-1:0]  red_sum,
   output logic [SUM_W-1:0]  green_sum,
   output logic [SUM_W-1:0]  blue_sum,
   output logic [4:0]        state_q,
   output logic              done
);

   typedef enum logic [4:0] {
      IDLE     = 5'b00001,
      SUM_RUN  = 5'b00010,
      SUM_DONE = 5'b00100,
      BG_RUN   = 5'b01000,
      BG_DONE  = 5'b10000
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt_q;
   logic [SUM_W-1:0]   red_sum_q, green_sum_q, blue_sum_q;
   logic [PIX_W-1:0]   red_p1, green_p1, blue_p1;
   logic               is_bg_p1;
   logic               vld_p1;
   logic               rdy;
   logic               accept;
   logic [DIST_W-1:0]  dist_p0;
   logic               is_bg_p0;

   function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
      logic signed [PIX_W:0] d;
      logic signed [PIX_W:0] m;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      m = (d < 0) ? -d : d;
      return m[PIX_W-1:0];
   endfunction

   // Squares are formed at full distance width so the three-way sum cannot wrap.
   function automatic logic [DIST_W-1:0] square(input logic [PIX_W-1:0] v);
      logic [DIST_W-1:0] w;
      w = DIST_W'(v);
      return w * w;
   endfunction

   // Stage p0: colour distance of the pixel presented on the input
   always_comb begin
      dist_p0  = square(abs_diff(red_exp,   pix.in_red))
               + square(abs_diff(green_exp, pix.in_green))
               + square(abs_diff(blue_exp,  pix.in_blue));
      is_bg_p0 = (dist_p0 <= threshold);
   end

   always_comb begin
      rdy = 1'b0;
      case (state)
         SUM_RUN: rdy = 1'b1;
         BG_RUN:  rdy = (cnt_q < CNT_W'(NUM_PIXELS)) && (!vld_p1 || pix.out_ready);
         default: rdy = 1'b0;
      endcase
   end

   assign accept = pix.in_valid && rdy;

   // Stage p1: registered result and control state
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         cnt_q       <= '0;
         red_sum_q   <= '0;
         green_sum_q <= '0;
         blue_sum_q  <= '0;
         red_p1      <= '0;
         green_p1    <= '0;
         blue_p1     <= '0;
         is_bg_p1    <= 1'b0;
         vld_p1      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start_Sum) begin
                  state       <= SUM_RUN;
                  cnt_q       <= '0;
                  red_sum_q   <= '0;
                  green_sum_q <= '0;
                  blue_sum_q  <= '0;
               end else if (Start_BgRemoval) begin
                  state <= BG_RUN;
                  cnt_q <= '0;
               end
            end
            SUM_RUN: begin
               if (accept) begin
                  red_sum_q   <= red_sum_q   + SUM_W'(pix.in_red);
                  green_sum_q <= green_sum_q + SUM_W'(pix.in_green);
                  blue_sum_q  <= blue_sum_q  + SUM_W'(pix.in_blue);
                  cnt_q       <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(NUM_PIXELS-1))
                     state <= SUM_DONE;
               end
            end
            SUM_DONE: begin
               if (Ack)
                  state <= IDLE;
            end
            BG_RUN: begin
               if (accept) begin
                  red_p1   <= is_bg_p0 ? bg_red   : pix.in_red;
                  green_p1 <= is_bg_p0 ? bg_green : pix.in_green;
                  blue_p1  <= is_bg_p0 ? bg_blue  : pix.in_blue;
                  is_bg_p1 <= is_bg_p0;
                  vld_p1   <= 1'b1;
                  cnt_q    <= cnt_q + 1'b1;
               end else if (pix.out_ready) begin
                  vld_p1 <= 1'b0;
               end
               // Once every pixel is accepted, the single held result is the last one.
               if ((cnt_q == CNT_W'(NUM_PIXELS)) && vld_p1 && pix.out_ready)
                  state <= BG_DONE;
            end
            BG_DONE: begin
               if (Ack)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pix.in_ready  = rdy;
   assign pix.out_valid = vld_p1;
   assign pix.out_red   = red_p1;
   assign pix.out_green = green_p1;
   assign pix.out_blue  = blue_p1;
   assign pix.out_is_bg = is_bg_p1;
   assign red_sum       = red_sum_q;
   assign green_sum     = green_sum_q;
   assign blue_sum      = blue_sum_q;
   assign state_q       = state;
   assign done          = (state == SUM_DONE) || (state == BG_DONE);

endmodule

// File: tb/tb_bg_remove_engine.sv
// Directed bench for bg_remove_engine: sums, background replacement,
// back-pressure, start priority and mid-run reset.
module tb_bg_remove_engine;

   localparam int PIX_W  = 8;
   localparam int SUM_W  = 12;
   localparam int DIST_W = 2*PIX_W+2;

   localparam logic [4:0] S_IDLE     = 5'b00001;
   localparam logic [4:0] S_SUM_RUN  = 5'b00010;
   localparam logic [4:0] S_SUM_DONE = 5'b00100;
   localparam logic [4:0] S_BG_RUN   = 5'b01000;
   localparam logic [4:0] S_BG_DONE  = 5'b10000;

   // Stream vectors with exp=(100,100,100), threshold=300; BGF is the hand-derived
   // "distance <= threshold" flag for each pixel.
   localparam logic [7:0] PR  [0:15] = '{110,120,110,100,  0,255, 90,100,111,117,118,100,110,200,101,100};
   localparam logic [7:0] PG  [0:15] = '{100,100,110,100,  0,255,100, 90,110,100,100,100,110, 50,101,117};
   localparam logic [7:0] PB  [0:15] = '{100,100,110,100,  0,255,100,110,100,100,100, 83,111,100,101,105};
   localparam logic       BGF [0:15] = '{  1,  0,  1,  1,  0,  0,  1,  1,  1,  1,  0,  1,  0,  0,  1,  0};

   logic              Clk = 1'b0;
   logic              Reset;
   logic              Start_Sum, Start_BgRemoval, Ack;
   logic [PIX_W-1:0]  red_exp, green_exp, blue_exp;
   logic [DIST_W-1:0] threshold;
   logic [PIX_W-1:0]  bg_red, bg_green, bg_blue;
   logic [SUM_W-1:0]  red_sum, green_sum, blue_sum;
   logic [4:0]        state_q;
   logic              done;

   int checks = 0;
   int errors = 0;

   bg_remove_if #(.PIX_W(PIX_W)) pix ();

   bg_remove_engine #(
      .PIX_W(PIX_W), .NUM_PIXELS(16), .CNT_W(5), .SUM_W(SUM_W)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
      .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
      .threshold(threshold),
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
      .pix(pix),
      .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum),
      .state_q(state_q), .done(done)
   );

   always #5 Clk = ~Clk;

   task automatic test_reset;
      Reset = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      checks++;
      if ({state_q, done, pix.out_valid, pix.in_ready, pix.out_is_bg} !== {S_IDLE, 4'b0000}) begin
         errors++;
         $display("FAIL reset_ctrl got state=%b done=%b ov=%b ir=%b bg=%b want state=00001 rest 0",
                  state_q, done, pix.out_valid, pix.in_ready, pix.out_is_bg);
      end
      checks++;
      if ({red_sum, green_sum, blue_sum, pix.out_red, pix.out_green, pix.out_blue} !== '0) begin
         errors++;
         $display("FAIL reset_data got sums=%0d/%0d/%0d out=%0d/%0d/%0d want all 0",
                  red_sum, green_sum, blue_sum, pix.out_red, pix.out_green, pix.out_blue);
      end
      Reset = 1'b0;
   endtask

   task automatic test_sum;
      int acc = 0;
      int cyc = 0;
      @(negedge Clk);
      Start_Sum = 1'b1;
      @(negedge Clk);
      Start_Sum = 1'b0;
      checks++;
      if (state_q !== S_SUM_RUN) begin
         errors++;
         $display("FAIL sum_enter got state=%b want %b", state_q, S_SUM_RUN);
      end
      while (acc < 16 && cyc < 200) begin
         pix.in_valid = (cyc % 3) != 2;
         pix.in_red = 8'd10; pix.in_green = 8'd20; pix.in_blue = 8'd30;
         #1;
         checks++;
         if (pix.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sum_out_valid got %b want 0", pix.out_valid);
         end
         if (pix.in_valid && pix.in_ready) acc++;
         @(negedge Clk);
         cyc++;
      end
      pix.in_valid = 1'b0;
      checks++;
      if (acc != 16) begin
         errors++;
         $display("FAIL sum_accepts got %0d want 16", acc);
      end
      checks++;
      if ({state_q, done, pix.in_ready} !== {S_SUM_DONE, 2'b10}) begin
         errors++;
         $display("FAIL sum_done got state=%b done=%b ir=%b want 00100 1 0", state_q, done, pix.in_ready);
      end
      checks++;
      if ({red_sum, green_sum, blue_sum} !== {12'd160, 12'd320, 12'd480}) begin
         errors++;
         $display("FAIL sum_values got %0d/%0d/%0d want 160/320/480", red_sum, green_sum, blue_sum);
      end
      @(negedge Clk);
      checks++;
      if ({state_q, done} !== {S_SUM_DONE, 1'b1}) begin
         errors++;
         $display("FAIL sum_hold got state=%b done=%b want 00100 1", state_q, done);
      end
      Ack = 1'b1;
      @(negedge Clk);
      Ack = 1'b0;
      checks++;
      if ({state_q, done, red_sum, blue_sum} !== {S_IDLE, 1'b0, 12'd160, 12'd480}) begin
         errors++;
         $display("FAIL sum_ack got state=%b done=%b r=%0d b=%0d want 00001 0 160 480",
                  state_q, done, red_sum, blue_sum);
      end
   endtask

   // Runs one full background-removal operation from IDLE, stalling out_ready
   // for stall_len cycles starting at loop cycle stall_at.
   task automatic run_bg_stream(input int stall_at, input int stall_len, output int n_stall);
      int ii = 0;
      int oi = 0;
      int cyc = 0;
      logic held = 1'b0;
      logic [PIX_W-1:0] hr = '0, hg = '0, hb = '0;
      logic hbg = 1'b0;
      logic [PIX_W-1:0] er, eg, eb;
      n_stall = 0;
      red_exp = 8'd100; green_exp = 8'd100; blue_exp = 8'd100;
      threshold = 18'd300;
      bg_red = 8'd5; bg_green = 8'd6; bg_blue = 8'd7;
      pix.out_ready = 1'b1;
      Start_BgRemoval = 1'b1;
      @(negedge Clk);
      Start_BgRemoval = 1'b0;
      checks++;
      if (state_q !== S_BG_RUN) begin
         errors++;
         $display("FAIL bg_enter got state=%b want %b", state_q, S_BG_RUN);
      end
      while (oi < 16 && cyc < 300) begin
         pix.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         pix.in_valid = (ii < 16);
         if (ii < 16) begin
            pix.in_red = PR[ii]; pix.in_green = PG[ii]; pix.in_blue = PB[ii];
         end
         #1;
         if (held) begin
            checks++;
            if ({pix.out_valid, pix.out_red, pix.out_green, pix.out_blue, pix.out_is_bg} !==
                {1'b1, hr, hg, hb, hbg}) begin
               errors++;
               $display("FAIL bg_stall_hold got v=%b %0d/%0d/%0d bg=%b want 1 %0d/%0d/%0d bg=%b",
                        pix.out_valid, pix.out_red, pix.out_green, pix.out_blue, pix.out_is_bg,
                        hr, hg, hb, hbg);
            end
         end
         held = 1'b0;
         if (pix.out_valid && !pix.out_ready) begin
            n_stall++;
            checks++;
            if (pix.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bg_stall_in_ready got %b want 0", pix.in_ready);
            end
            held = 1'b1;
            hr = pix.out_red; hg = pix.out_green; hb = pix.out_blue; hbg = pix.out_is_bg;
         end
         if (pix.out_valid && pix.out_ready) begin
            er = BGF[oi] ? 8'd5 : PR[oi];
            eg = BGF[oi] ? 8'd6 : PG[oi];
            eb = BGF[oi] ? 8'd7 : PB[oi];
            checks++;
            if ({pix.out_red, pix.out_green, pix.out_blue, pix.out_is_bg} !== {er, eg, eb, BGF[oi]}) begin
               errors++;
               $display("FAIL bg_pixel%0d got %0d/%0d/%0d bg=%b want %0d/%0d/%0d bg=%b", oi,
                        pix.out_red, pix.out_green, pix.out_blue, pix.out_is_bg, er, eg, eb, BGF[oi]);
            end
            oi++;
         end
         if (pix.in_valid && pix.in_ready) ii++;
         @(negedge Clk);
         cyc++;
      end
      pix.in_valid = 1'b0;
      pix.out_ready = 1'b1;
      checks++;
      if (oi != 16 || ii != 16) begin
         errors++;
         $display("FAIL bg_counts got out=%0d in=%0d want 16 16", oi, ii);
      end
      checks++;
      if ({state_q, done, pix.out_valid, pix.in_ready} !== {S_BG_DONE, 3'b100}) begin
         errors++;
         $display("FAIL bg_done got state=%b done=%b ov=%b ir=%b want 10000 1 0 0",
                  state_q, done, pix.out_valid, pix.in_ready);
      end
      Ack = 1'b1;
      @(negedge Clk);
      Ack = 1'b0;
      checks++;
      if ({state_q, done} !== {S_IDLE, 1'b0}) begin
         errors++;
         $display("FAIL bg_ack got state=%b done=%b want 00001 0", state_q, done);
      end
   endtask

   task automatic test_bg_removal;
      int ns;
      run_bg_stream(1000, 0, ns);
      checks++;
      if (red_sum !== 12'd160) begin
         errors++;
         $display("FAIL bg_sums_untouched got %0d want 160", red_sum);
      end
   endtask

   task automatic test_backpressure;
      int ns;
      run_bg_stream(6, 5, ns);
      checks++;
      if (ns != 5) begin
         errors++;
         $display("FAIL bp_stall_cycles got %0d want 5", ns);
      end
   endtask

   task automatic test_start_priority;
      @(negedge Clk);
      Start_Sum = 1'b1;
      Start_BgRemoval = 1'b1;
      @(negedge Clk);
      Start_Sum = 1'b0;
      Start_BgRemoval = 1'b0;
      checks++;
      if (state_q !== S_SUM_RUN) begin
         errors++;
         $display("FAIL prio_both got state=%b want %b", state_q, S_SUM_RUN);
      end
      pix.in_valid = 1'b1;
      pix.in_red = 8'd1; pix.in_green = 8'd2; pix.in_blue = 8'd3;
      repeat (16) @(negedge Clk);
      pix.in_valid = 1'b0;
      checks++;
      if ({state_q, red_sum, green_sum, blue_sum} !== {S_SUM_DONE, 12'd16, 12'd32, 12'd48}) begin
         errors++;
         $display("FAIL prio_sum got state=%b sums=%0d/%0d/%0d want 00100 16/32/48",
                  state_q, red_sum, green_sum, blue_sum);
      end
      Ack = 1'b1;
      @(negedge Clk);
      Ack = 1'b0;
      Start_BgRemoval = 1'b1;
      @(negedge Clk);
      Start_BgRemoval = 1'b0;
      Start_Sum = 1'b1;
      @(negedge Clk);
      Start_Sum = 1'b0;
      checks++;
      if ({state_q, red_sum} !== {S_BG_RUN, 12'd16}) begin
         errors++;
         $display("FAIL prio_start_in_bg got state=%b r=%0d want 01000 16", state_q, red_sum);
      end
      Ack = 1'b1;
      @(negedge Clk);
      Ack = 1'b0;
      checks++;
      if (state_q !== S_BG_RUN) begin
         errors++;
         $display("FAIL prio_ack_in_bg got state=%b want %b", state_q, S_BG_RUN);
      end
   endtask

   // Continues the BG_RUN left by test_start_priority.
   task automatic test_reset_mid;
      int ii = 0;
      int cyc = 0;
      int ns;
      pix.out_ready = 1'b1;
      while (ii < 7 && cyc < 100) begin
         pix.in_valid = 1'b1;
         pix.in_red = PR[ii]; pix.in_green = PG[ii]; pix.in_blue = PB[ii];
         #1;
         if (pix.in_ready) ii++;
         @(negedge Clk);
         cyc++;
      end
      checks++;
      if (ii != 7 || pix.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_setup got accepted=%0d ov=%b want 7 1", ii, pix.out_valid);
      end
      pix.in_red = PR[7]; pix.in_green = PG[7]; pix.in_blue = PB[7];
      Reset = 1'b1;
      Start_Sum = 1'b1;
      Ack = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      Start_Sum = 1'b0;
      Ack = 1'b0;
      pix.in_valid = 1'b0;
      checks++;
      if ({state_q, done, pix.out_valid, pix.in_ready, pix.out_is_bg} !== {S_IDLE, 4'b0000}) begin
         errors++;
         $display("FAIL rstmid_ctrl got state=%b done=%b ov=%b ir=%b bg=%b want 00001 0 0 0 0",
                  state_q, done, pix.out_valid, pix.in_ready, pix.out_is_bg);
      end
      checks++;
      if ({red_sum, green_sum, blue_sum, pix.out_red, pix.out_green, pix.out_blue} !== '0) begin
         errors++;
         $display("FAIL rstmid_data got sums=%0d/%0d/%0d out=%0d/%0d/%0d want all 0",
                  red_sum, green_sum, blue_sum, pix.out_red, pix.out_green, pix.out_blue);
      end
      @(negedge Clk);
      checks++;
      if (state_q !== S_IDLE) begin
         errors++;
         $display("FAIL rstmid_stay_idle got state=%b want %b", state_q, S_IDLE);
      end
      run_bg_stream(3, 2, ns);
   endtask

   initial begin
      Reset = 1'b1;
      Start_Sum = 1'b0; Start_BgRemoval = 1'b0; Ack = 1'b0;
      red_exp = '0; green_exp = '0; blue_exp = '0; threshold = '0;
      bg_red = '0; bg_green = '0; bg_blue = '0;
      pix.in_valid = 1'b0; pix.out_ready = 1'b1;
      pix.in_red = '0; pix.in_green = '0; pix.in_blue = '0;

      test_reset();
      test_sum();
      test_bg_removal();
      test_backpressure();
      test_start_priority();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bg_remove_engine.md
BG_REMOVE_ENGINE -- requirements
Module: bg_remove_engine

Interface
REQ-001 Parameter PIX_W, default 8, bits per colour channel.
REQ-002 Parameter NUM_PIXELS, default 16, pixels per frame segment handled per operation (>=2).
REQ-003 Parameter CNT_W, default 5, pixel counter width (2^CNT_W > NUM_PIXELS).
REQ-004 Parameter SUM_W, default 12, per-channel sum width (>= PIX_W+CNT_W-1).
REQ-005 Derived DIST_W = 2*PIX_W+2, distance-squared width.
REQ-006 Clk  in  1  sole clock, rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 Start_Sum  in  1  pulse: begin sum operation.
REQ-009 Start_BgRemoval  in  1  pulse: begin background-removal operation.
REQ-010 Ack  in  1  acknowledge done, return to IDLE.
REQ-011 red_exp/green_exp/blue_exp  in  PIX_W each  expected background colour.
REQ-012 threshold  in  DIST_W  distance-squared threshold.
REQ-013 bg_red/bg_green/bg_blue  in  PIX_W each  replacement colour.
REQ-014 in_valid  in  1; in_ready  out  1; in_red/in_green/in_blue  in  PIX_W each  pixel input stream.
REQ-015 out_valid  out  1; out_ready  in  1; out_red/out_green/out_blue  out  PIX_W each; out_is_bg  out  1  pixel output stream.
REQ-016 red_sum/green_sum/blue_sum  out  SUM_W each  channel sums.
REQ-017 state_q  out  5  one-hot {BG_DONE,BG_RUN,SUM_DONE,SUM_RUN,IDLE}; done  out  1  = SUM_DONE|BG_DONE.

Function
REQ-018 States IDLE, SUM_RUN, SUM_DONE, BG_RUN, BG_DONE, exactly one active.
REQ-019 Start pulses accepted only in IDLE; both asserted same cycle -> Start_Sum wins; starts elsewhere ignored.
REQ-020 IDLE->SUM_RUN on Start_Sum: sums and counter cleared same edge.
REQ-021 SUM_RUN: in_ready=1; each in_valid&in_ready adds zero-extended channel to its sum, counter+1; out_valid stays 0.
REQ-022 Acceptance of pixel NUM_PIXELS-1 (0-based) -> SUM_DONE next edge, sums final then; in_ready=0 outside SUM_RUN/BG_RUN.
REQ-023 SUM_DONE: sums held; Ack -> IDLE; sums retained until next Start_Sum.
REQ-024 IDLE->BG_RUN on Start_BgRemoval: counter cleared; sums untouched.
REQ-025 BG_RUN: in_ready = (counter<NUM_PIXELS) & (!out_valid | out_ready).
REQ-026 Per accepted pixel: d_c=|exp_c-in_c| (PIX_W unsigned); dist=d_r^2+d_g^2+d_b^2 at DIST_W, no overflow.
REQ-027 dist>threshold: output = input, out_is_bg=0; dist<=threshold (equality included): output = bg colour, out_is_bg=1.
REQ-028 Latency: result registered, out_valid next edge after accept; full throughput 1 pixel/cycle when out_ready=1.
REQ-029 out_valid&!out_ready: output data, out_is_bg frozen; in_ready=0.
REQ-030 BG_RUN->BG_DONE on edge where last (NUM_PIXELS-th) output handshakes; out_valid 0 in BG_DONE.
REQ-031 BG_DONE: Ack -> IDLE; Ack in other states ignored.
REQ-032 Threshold, expected and bg colours sampled per accepted pixel (not latched at start).

Reset
REQ-033 Reset high at edge: state IDLE, counter 0, sums 0, out_valid 0, out colours 0, out_is_bg 0, in_ready 0, done 0.
REQ-034 Reset mid-operation aborts; in-flight output discarded; Reset dominates Start and Ack same cycle.

Verification
REQ-035 Start_Sum, 16 pixels (r=10,g=20,b=30), gaps in in_valid -> SUM_DONE, sums 160/320/480, done until Ack.
REQ-036 exp=(100,100,100), threshold=300, pixels (110,100,100) and (120,100,100) -> first replaced by bg, out_is_bg=1 (dist 100); second passes (dist 400).
REQ-037 Pixel with dist == threshold -> replaced (equality = background).
REQ-038 out_ready held 0 for 5 cycles mid-stream -> output stable, in_ready 0, no pixel lost or duplicated, 16 outputs total.
REQ-039 Start_Sum and Start_BgRemoval same cycle -> SUM_RUN; Start during BG_RUN ignored.
REQ-040 Reset asserted at pixel 7 of BG_RUN -> next cycle IDLE, all outputs 0; new run completes normally.
